pezaris_seq_mult8: RTL
======================

Name: pezaris_seq_mult8

Overview:
- Iterative 8x8 two's-complement multiplier built on the Pezaris carry-save array scheme.
- Folds the array into one registered carry-save row evaluated once per cycle, followed by one ripple carry-propagate row (type-2 full adders, as in the final U row).
- Sits directly upstream of the product consumer.
- Replaces the fully combinational array where area matters more than latency; valid/ready on both sides.

Parameters:
- W, 8, operand width (fixed at 8 for this block; product width 2*W = 16)
- CNT_W, 3, width of row counter (log2 W)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  8  multiplicand, two's complement
- b  input  8  multiplier, two's complement
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  16  product a*b, two's complement

Behaviour:
- Reset (async, rst=1): state=IDLE, row counter=0, all internal sum/carry registers=0, p=0, out_valid=0, in_ready=1 (combinational from state, so high while in reset).
- States: IDLE, ROW, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E:
  - register a, b
  - clear sum/carry rows, counter=0
  - go to ROW
- ROW: one partial-product row per cycle, counter 0..7.
  - Rows 0..6: bits a[i]&b[k] for i<7 use type-1 adders; a[7]&b[k] term is negated (Pezaris sign-bit handling).
  - Row 7: a[i]&b[7] negated for i<7; a[7]&b[7] not negated.
  - Each cycle adds the row into registered (sum, carry) in carry-save form; the low sum bit retires into the product low half.
  - At counter=7, go to FINAL.
- FINAL: one-cycle ripple row over the remaining 7 sum/carry bit pairs using type-2 adders (first two inputs negated). Result and retired low bits are loaded into p; out_valid=1; go to DONE.
- Timing: p and out_valid update at edge E+9, so latency is 9 cycles.
- DONE: p held stable and out_valid=1 until out_ready=1. On the out_valid&out_ready edge: out_valid=0, go to IDLE.
  - p keeps its value after handshake until the next FINAL.
  - in_ready=0 in DONE; no accept in the same cycle as output handshake.
- in_ready=0 in ROW, FINAL and DONE. in_valid and operand changes are ignored there. Throughput is one product per 10+ cycles.
- Arithmetic: exact 16-bit two's-complement product for all 65536 operand pairs; no overflow is possible (max |p| = 16384).
- rst asserted mid-operation (any state): immediate abort to reset values; the partial result is discarded and no out_valid pulse occurs.
- out_ready while out_valid=0: ignored.

Optional Feature:
- PEZARIS_SEQ_MULT8_UNSIGNED_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled with a, b at accept.
  - signed_mode=0: all negations are disabled and type-1 adders are used throughout, giving an unsigned 8x8 product in p (0..65025).
  - signed_mode=1: behaviour as above.
- Undefined: the port is absent and the block is signed only.

Test Plan:
- Reset, then a=3, b=5 accepted at edge E with out_ready=1 -> out_valid rises at E+9, p=0x000F, in_ready returns 1 one cycle after handshake.
- a=-128 (0x80), b=-128 -> p=0x4000; a=-128, b=127 (0x7F) -> p=0xC080; a=-1, b=-1 -> p=0x0001.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> p and out_valid held stable, in_ready=0, a new in_valid is not accepted; release -> handshake, IDLE.
- rst pulsed at edge E+4 mid-ROW -> p=0, out_valid=0, in_ready=1 asynchronously. Next operands a=7, b=-2 -> p=0xFFF2 after 9 cycles.
- Exhaustive/random sweep of a, b vs reference a*b (signed); with PEZARIS_SEQ_MULT8_UNSIGNED_EN, signed_mode=0, a=0xFF, b=0xFF -> p=0xFE01.
- Operands changed and in_valid toggled during ROW -> result unaffected (a=12, b=-11 gives p=0xFF7C).

Source files
------------

// File: rtl/pezaris_seq_mult8.sv
// Iterative 8x8 two's-complement multiplier: one registered carry-save row per cycle, then one ripple row; 9-cycle latency.
// Optional unsigned mode via `define PEZARIS_SEQ_MULT8_UNSIGNED_EN (adds signed_mode port).
module pezaris_seq_mult8 #(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PEZARIS_SEQ_MULT8_UNSIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROW   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(W-1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic [W-1:0]     carry_r;
  logic [W-1:0]     lo_r;
  logic             sm_r;

  logic [W-1:0]     pp;
  logic [W-1:0]     rs;
  logic [W-1:0]     rc;
  logic [W-1:0]     sum_n;
  logic [W-1:0]     fin;
  logic [W-1:0]     hi;
  logic             last_row;
  logic             rip_c;

  assign in_ready = (state == S_IDLE);
  assign last_row = (cnt == LAST_ROW);

`ifdef PEZARIS_SEQ_MULT8_UNSIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_r <= 1'b1;
    end else if (state == S_IDLE && in_valid) begin
      sm_r <= signed_mode;
    end
  end
`else
  assign sm_r = 1'b1;
`endif

  // Negative-weight sign terms are carried as inverted bits; their constant
  // offsets (+2^8 and +2^15 mod 2^16) are injected after row 0 and in the final row.
  always_comb begin
    pp = '0;
    for (int i = 0; i < W; i++) begin
      pp[i] = a_r[i] & b_r[cnt];
      if (i < W-1) begin
        if (sm_r && last_row) pp[i] = ~pp[i];
      end else begin
        if (sm_r && !last_row) pp[i] = ~pp[i];
      end
    end
    rs = pp ^ sum_r ^ carry_r;
    rc = (pp & sum_r) | (pp & carry_r) | (sum_r & carry_r);
    sum_n = {(sm_r && cnt == '0), rs[W-1:1]};
  end

  always_comb begin
    fin   = '0;
    rip_c = 1'b0;
    for (int i = 0; i < W; i++) begin
      fin[i] = sum_r[i] ^ carry_r[i] ^ rip_c;
      rip_c  = (sum_r[i] & carry_r[i]) | (sum_r[i] & rip_c) | (carry_r[i] & rip_c);
    end
    hi = fin ^ {sm_r, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry_r   <= '0;
      lo_r      <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
            state   <= S_ROW;
          end
        end
        S_ROW: begin
          sum_r   <= sum_n;
          carry_r <= rc;
          lo_r    <= {rs[0], lo_r[W-1:1]};
          cnt     <= cnt + 1'b1;
          if (last_row) state <= S_FINAL;
        end
        S_FINAL: begin
          p         <= {hi, lo_r};
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
